hamming_secded_ser_enc: RTL and testbench

Parametrised serial extended-Hamming (SECDED) encoder, successor to the fixed (16,11) serial encoder.
- Accepts K data bits one per accepted beat, builds an N = 2^R bit codeword, and streams it out serially under a valid/ready handshake.
- Codeword position 0 carries the overall parity. Positions 2^i carry Hamming parity. All other positions carry data in ascending order.
- Sits between the serial source and the channel model; the matching decoder consumes its output.

---
 rtl/hamming_pkg.sv | 50 +++++
 rtl/hamming_parity_gen.sv | 28 ++
 rtl/hamming_secded_ser_enc.sv | 119 +++++++++++
 tb/tb_hamming_secded_ser_enc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the serial Hamming/SECDED codec.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ENCODE  = 2'd2,
    SEND    = 2'd3
  } state_e;

  function automatic int n_of(input int r);
    return 1 << r;
  endfunction

  function automatic int k_of(input int r);
    return (1 << r) - r - 1;
  endfunction

  function automatic bit is_pow2(input int idx);
    int c;
    c = 0;
    for (int b = 0; b < 32; b++) c += (idx >> b) & 1;
    return c == 1;
  endfunction

  // j-th codeword position that is neither 0 nor a power of two
  function automatic int data_pos(input int j);
    int seen;
    int pos;
    seen = 0;
    pos  = 0;
    for (int p = 3; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (seen == j) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

  // positions 1..2^r-1 whose index has bit i set
  function automatic logic [63:0] cover_mask(input int r, input int i);
    logic [63:0] m;
    m = '0;
    for (int idx = 1; idx < (1 << r); idx++)
      if (((idx >> i) & 1) == 1) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Fills Hamming parity (positions 2^i) and optional overall parity (position 0).
// Parity positions of the input are included, so a received word yields its syndrome.
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter bit EXTENDED = 1'b1,
  localparam int N       = 1 << R
)(
  input  logic [N-1:0] placed,
  output logic [N-1:0] cw
);

  logic [N-1:1] body;

  for (genvar idx = 1; idx < N; idx++) begin : g_pos
    if (is_pow2(idx)) begin : g_par
      localparam logic [63:0] COVER = cover_mask(R, $clog2(idx));
      assign body[idx] = ^(placed & COVER[N-1:0]);
    end else begin : g_dat
      assign body[idx] = placed[idx];
    end
  end

  assign cw[N-1:1] = body;
  assign cw[0]     = EXTENDED ? (^body ^ placed[0]) : 1'b0;

endmodule

// File: rtl/hamming_secded_ser_enc.sv
// Serial extended-Hamming encoder: collect K bits, encode in one cycle,
// then stream the codeword out under valid/ready.
module hamming_secded_ser_enc
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter bit EXTENDED = 1'b1,
  localparam int N       = n_of(R),
  localparam int K       = k_of(R),
  localparam int CW      = $clog2(N)
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_sof,
  output logic         dout_eof,
  output logic [N-1:0] codeword,
  output logic         cw_valid,
  output logic         busy
);

  localparam logic [CW-1:0] START  = EXTENDED ? CW'(0) : CW'(1);
  localparam logic [CW-1:0] LAST_D = CW'(K - 1);
  localparam logic [CW-1:0] LAST_P = CW'(N - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [K-1:0]    data_q;
  logic            live_q;
  logic            accept;
  logic [N-1:0]    placed;
  logic [N-1:0]    cw_gen;

  // live_q keeps din_ready low until the first edge after reset release
  assign din_ready  = live_q & ((state_q == IDLE) | (state_q == COLLECT));
  assign accept     = din_valid & din_ready;
  assign dout_valid = (state_q == SEND);
  assign dout       = dout_valid & codeword[cnt_q];
  assign dout_sof   = dout_valid & (cnt_q == START);
  assign dout_eof   = dout_valid & (cnt_q == LAST_P);
  assign busy       = (state_q != IDLE);

  for (genvar j = 0; j < K; j++) begin : g_data
    assign placed[data_pos(j)] = data_q[j];
  end
  for (genvar i = 0; i < R; i++) begin : g_hole
    assign placed[1 << i] = 1'b0;
  end
  assign placed[0] = 1'b0;

  hamming_parity_gen #(
    .R        (R),
    .EXTENDED (EXTENDED)
  ) u_par (
    .placed (placed),
    .cw     (cw_gen)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_D) begin
            state_d = ENCODE;
            cnt_d   = '0;
          end else begin
            state_d = COLLECT;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      ENCODE: begin
        state_d = SEND;
        cnt_d   = START;
      end
      SEND: begin
        if (dout_ready) begin
          if (cnt_q == LAST_P) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      codeword <= '0;
      cw_valid <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      live_q   <= 1'b1;
      cw_valid <= (state_q == ENCODE);
      // first accepted bit ends up in data_q[0] after K shifts
      if (accept) data_q <= K'({din, data_q} >> 1);
      if (state_q == ENCODE) codeword <= cw_gen;
    end
  end

endmodule

// File: tb/tb_hamming_secded_ser_enc.sv
// Directed bench for the serial SECDED encoder (R=4 extended, R=3 extended/plain).
module tb_hamming_secded_ser_enc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        din, din_valid, din_ready, dout, dout_valid, dout_ready;
  logic        dout_sof, dout_eof, cw_valid, busy;
  logic [15:0] codeword;

  logic        din3, din_valid3, dout_ready3;
  logic        rdy3e, do3e, dv3e, sof3e, eof3e, cwv3e, busy3e;
  logic        rdy3p, do3p, dv3p, sof3p, eof3p, cwv3p, busy3p;
  logic [7:0]  cw3e, cw3p;

  hamming_secded_ser_enc #(.R(4), .EXTENDED(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_sof(dout_sof),
    .dout_eof(dout_eof), .codeword(codeword), .cw_valid(cw_valid), .busy(busy));

  hamming_secded_ser_enc #(.R(3), .EXTENDED(1'b1)) u3e (
    .clk(clk), .rst_n(rst_n), .din(din3), .din_valid(din_valid3), .din_ready(rdy3e),
    .dout(do3e), .dout_valid(dv3e), .dout_ready(dout_ready3), .dout_sof(sof3e),
    .dout_eof(eof3e), .codeword(cw3e), .cw_valid(cwv3e), .busy(busy3e));

  hamming_secded_ser_enc #(.R(3), .EXTENDED(1'b0)) u3p (
    .clk(clk), .rst_n(rst_n), .din(din3), .din_valid(din_valid3), .din_ready(rdy3p),
    .dout(do3p), .dout_valid(dv3p), .dout_ready(dout_ready3), .dout_sof(sof3p),
    .dout_eof(eof3p), .codeword(cw3p), .cw_valid(cwv3p), .busy(busy3p));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [10:0] data;
    logic [15:0] cw;
    bit          gaps;
    bit          stall;
    bit          hold;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    check({nm, " outs"}, {25'd0, din_ready, dout, dout_valid, dout_sof, dout_eof, cw_valid, busy}, 0);
    check({nm, " codeword"}, {16'd0, codeword}, 0);
  endtask

  // drives bits data[0..count-1]; the last accept happens on the edge after return
  task automatic feed4(input string nm, input logic [10:0] data, input int count, input bit gaps);
    int j;
    j = 0;
    for (int c = 0; c < 300 && j < count; c++) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) begin
        din_valid = 1'b0;
      end else begin
        din_valid = 1'b1;
        din       = data[j];
        if (din_ready) j++;
      end
    end
    check({nm, " feed"}, j, count);
  endtask

  task automatic frame4(input string nm, input logic [10:0] data, input logic [15:0] exp_cw,
                        input bit gaps, input bit stall, input bit hold);
    int lat, idx, sof_at, eof_at, pulses, stall_err, rdy_err;
    bit found, tog, stalled;
    logic prev;
    logic [15:0] stream;
    lat = 0; idx = 0; sof_at = -1; eof_at = -1; pulses = 0; stall_err = 0; rdy_err = 0;
    found = 0; tog = 0; stalled = 0; prev = 0; stream = '0;
    feed4(nm, data, 11, gaps);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      din_valid = hold;
      din       = 1'b1;
      lat++;
      if (din_ready) rdy_err++;
      if (dout_valid) found = 1;
    end
    check({nm, " latency"}, lat, 2);
    check({nm, " codeword"}, {16'd0, codeword}, {16'd0, exp_cw});
    for (int c = 0; c < 200 && dout_valid; c++) begin
      if (cw_valid) pulses++;
      if (din_ready) rdy_err++;
      if (stalled && dout !== prev) stall_err++;
      if (dout_sof) sof_at = idx;
      if (dout_eof) eof_at = idx;
      dout_ready = stall ? tog : 1'b1;
      tog = ~tog;
      if (dout_ready) begin
        if (idx < 16) stream[idx] = dout;
        idx++;
      end
      stalled = !dout_ready;
      prev    = dout;
      @(negedge clk);
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    check({nm, " stream"}, {16'd0, stream}, {16'd0, exp_cw});
    check({nm, " nbits"}, idx, 16);
    check({nm, " sof"}, sof_at, 0);
    check({nm, " eof"}, eof_at, 15);
    check({nm, " cw_pulses"}, pulses, 1);
    check({nm, " stall_stable"}, stall_err, 0);
    check({nm, " ready_low"}, rdy_err, 0);
    check({nm, " ready_after"}, {31'd0, din_ready}, 1);
    check({nm, " busy_after"}, {31'd0, busy}, 0);
    check({nm, " cw_held"}, {16'd0, codeword}, {16'd0, exp_cw});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [3:0] d3;
    logic [7:0] se, sp;
    int ce, cp, sofe, eofe, sofp, eofp;
    bit found;

    vecs[0] = '{"all_ones",   11'h7FF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"d0",         11'h001, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"d10_stall",  11'h400, 16'h8117, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"zero_hold",  11'h000, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"d4_gaps",    11'h010, 16'h0303, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"d1_stall",   11'h002, 16'h0033, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{"d10_gaps",   11'h400, 16'h8117, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"ones_gstal", 11'h7FF, 16'hFFFF, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    din3 = 1'b0; din_valid3 = 1'b0; dout_ready3 = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    check("reset r3 cw", {16'd0, cw3e, cw3p}, 0);
    rst_n = 1'b1;
    #1 check("ready before edge", {31'd0, din_ready}, 0);
    @(negedge clk);
    check("ready after edge", {31'd0, din_ready}, 1);

    // R=3 extended and plain, same data stream
    d3 = 4'b1101;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("r3 ready", {30'd0, rdy3e, rdy3p}, 3);
      din_valid3 = 1'b1;
      din3       = d3[j];
    end
    @(negedge clk);
    din_valid3 = 1'b0;
    se = '0; sp = '0; ce = 0; cp = 0; sofe = -1; eofe = -1; sofp = -1; eofp = -1;
    for (int c = 0; c < 20; c++) begin
      if (dv3e) begin
        if (sof3e) sofe = ce;
        if (eof3e) eofe = ce;
        if (ce < 8) se[ce] = do3e;
        ce++;
      end
      if (dv3p) begin
        if (sof3p) sofp = cp;
        if (eof3p) eofp = cp;
        if (cp < 8) sp[cp] = do3p;
        cp++;
      end
      @(negedge clk);
    end
    check("r3e codeword", {24'd0, cw3e}, 32'hCC);
    check("r3e stream",   {24'd0, se},   32'hCC);
    check("r3e nbits",    ce, 8);
    check("r3e sof",      sofe, 0);
    check("r3e eof",      eofe, 7);
    check("r3p codeword", {24'd0, cw3p}, 32'hCC);
    check("r3p stream",   {24'd0, sp},   32'h66);
    check("r3p nbits",    cp, 7);
    check("r3p sof",      sofp, 0);
    check("r3p eof",      eofp, 6);

    for (int v = 0; v < 8; v++)
      frame4(vecs[v].name, vecs[v].data, vecs[v].cw, vecs[v].gaps, vecs[v].stall, vecs[v].hold);

    // abort mid-COLLECT
    feed4("abort_c", 11'h7FF, 5, 1'b0);
    @(negedge clk);
    din_valid = 1'b0;
    check("abort_c busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1 chk_idle("abort_c");
    @(negedge clk);
    rst_n = 1'b1;
    frame4("post_abort_c", 11'h001, 16'h000F, 1'b0, 1'b0, 1'b0);

    // abort mid-SEND
    feed4("abort_s", 11'h7FF, 11, 1'b0);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      din_valid = 1'b0;
      if (dout_valid) found = 1;
    end
    repeat (5) @(negedge clk);
    check("abort_s sending", {30'd0, busy, dout_valid}, 3);
    rst_n = 1'b0;
    #1 chk_idle("abort_s");
    @(negedge clk);
    rst_n = 1'b1;
    frame4("post_abort_s", 11'h400, 16'h8117, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
